// File: rtl/if_stage_pkg.sv
// Shared definitions for the LoongArch instruction-fetch stage: bus widths,
// reset fetch address and the fetch FSM state encoding.
package if_stage_pkg;

    localparam int BR_BUS_LEN    = 33;
    localparam int IFREG_BUS_LEN = 64;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one outstanding SRAM-like fetch at a time,
// hands {inst, pc} to decode and redirects on taken branches.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     ID_allow_in,
    input  logic [BR_BUS_LEN-1:0]    BR_BUS,
    output logic                     IF_ready_go,
    output logic                     IFreg_valid,
    output logic [IFREG_BUS_LEN-1:0] IFreg_bus,
    output logic                     inst_sram_req,
    output logic                     inst_sram_wr,
    output logic [1:0]               inst_sram_size,
    output logic [3:0]               inst_sram_wstrb,
    output logic [31:0]              inst_sram_addr,
    output logic [31:0]              inst_sram_wdata,
    input  logic                     inst_sram_addr_ok,
    input  logic [31:0]              inst_sram_rdata,
    input  logic                     inst_sram_data_ok
);

    if_state_t   state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] inst_buf, inst_buf_n;
    logic [31:0] pc_buf, pc_buf_n;
    logic        cancel, cancel_n;
    logic        req_c;

    logic [31:0] br_target;
    logic        br_taken;
    logic        redirect;

    assign {br_target, br_taken} = BR_BUS;
    // A taken branch only counts once decode actually lets it go.
    assign redirect = br_taken & ID_allow_in;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            inst_buf <= 32'd0;
            pc_buf   <= 32'd0;
            cancel   <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            inst_buf <= inst_buf_n;
            pc_buf   <= pc_buf_n;
            cancel   <= cancel_n;
        end
    end

    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        inst_buf_n  = inst_buf;
        pc_buf_n    = pc_buf;
        cancel_n    = cancel;
        req_c       = 1'b0;
        IF_ready_go = 1'b0;
        IFreg_valid = 1'b0;
        case (state)
            REQ: begin
                req_c = 1'b1;
                if (redirect)
                    fetch_pc_n = br_target;
                // An accepted old address must have its response dropped.
                if (inst_sram_addr_ok) begin
                    state_n  = WAIT;
                    cancel_n = redirect;
                end
            end
            WAIT: begin
                if (redirect)
                    fetch_pc_n = br_target;
                if (inst_sram_data_ok) begin
                    if (cancel) begin
                        cancel_n = 1'b0;
                        state_n  = REQ;
                    end else if (redirect) begin
                        state_n = REQ;
                    end else begin
                        inst_buf_n = inst_sram_rdata;
                        pc_buf_n   = fetch_pc;
                        state_n    = HOLD;
                    end
                end else if (redirect) begin
                    cancel_n = 1'b1;
                end
            end
            HOLD: begin
                IF_ready_go = 1'b1;
                IFreg_valid = ~redirect;
                if (redirect) begin
                    fetch_pc_n = br_target;
                    state_n    = REQ;
                end else if (ID_allow_in) begin
                    fetch_pc_n = fetch_pc + 32'd4;
                    state_n    = REQ;
                end
            end
            default: state_n = REQ;
        endcase
    end

    // The bus is registered so it keeps the last handed-off value in REQ/WAIT.
    assign IFreg_bus       = {inst_buf, pc_buf};
    assign inst_sram_req   = req_c & resetn;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'd0;

    a_data_ok_only_in_wait: assert property (
        @(posedge clk) disable iff (!resetn) inst_sram_data_ok |-> state == WAIT
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table, async-reset sequence and a
// randomized run checked against a program-order fetch model.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    typedef struct {
        string       name;
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] rdata;
        logic        allow;
        logic        br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        e_ready;
        logic        chk_bus;
        logic [63:0] e_bus;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ID_allow_in = 1'b0;
    logic [32:0] BR_BUS = '0;
    logic        IF_ready_go, IFreg_valid;
    logic [63:0] IFreg_bus;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0;
    logic        inst_sram_data_ok = 1'b0;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    if_stage dut (
        .clk(clk), .resetn(resetn), .ID_allow_in(ID_allow_in), .BR_BUS(BR_BUS),
        .IF_ready_go(IF_ready_go), .IFreg_valid(IFreg_valid), .IFreg_bus(IFreg_bus),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_rdata(inst_sram_rdata),
        .inst_sram_data_ok(inst_sram_data_ok)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3c5a_a5c3;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic aok, input logic dok, input logic [31:0] rd,
                          input logic al, input logic br, input logic [31:0] tgt,
                          input logic ereq, input logic [31:0] eaddr, input logic evalid,
                          input logic eready, input logic cbus, input logic [63:0] ebus);
        vec_t v;
        v.name = name; v.addr_ok = aok; v.data_ok = dok; v.rdata = rd; v.allow = al;
        v.br = br; v.tgt = tgt; v.e_req = ereq; v.e_addr = eaddr; v.e_valid = evalid;
        v.e_ready = eready; v.chk_bus = cbus; v.e_bus = ebus;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        inst_sram_addr_ok = v.addr_ok;
        inst_sram_data_ok = v.data_ok;
        inst_sram_rdata   = v.rdata;
        ID_allow_in       = v.allow;
        BR_BUS            = {v.tgt, v.br};
        #1;
        checkOutput({v.name, ".req"}, 64'(inst_sram_req), 64'(v.e_req));
        if (v.e_req)
            checkOutput({v.name, ".addr"}, 64'(inst_sram_addr), 64'(v.e_addr));
        checkOutput({v.name, ".valid"}, 64'(IFreg_valid), 64'(v.e_valid));
        checkOutput({v.name, ".ready"}, 64'(IF_ready_go), 64'(v.e_ready));
        if (v.chk_bus)
            checkOutput({v.name, ".bus"}, IFreg_bus, v.e_bus);
    endtask

    task automatic idleInputs();
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        ID_allow_in       = 1'b0;
        BR_BUS            = '0;
    endtask

    initial begin : main
        logic [31:0] i0, i1, i2, i3;
        logic        pending, data_ok, addr_ok, allow, br, redirect;
        logic [31:0] pend_addr, tgt, exp_pc;
        int          pend_wait, deliveries;
        logic        prev_stall;
        logic [63:0] prev_bus;

        i0 = 32'h1111_1111; i1 = 32'h2222_2222; i2 = 32'h3333_3333; i3 = 32'h4444_4444;

        #1;
        checkOutput("reset.req", 64'(inst_sram_req), 64'd0);
        checkOutput("reset.valid", 64'(IFreg_valid), 64'd0);
        checkOutput("reset.ready", 64'(IF_ready_go), 64'd0);
        checkOutput("reset.bus", IFreg_bus, 64'd0);
        checkOutput("reset.size", 64'(inst_sram_size), 64'd2);
        @(negedge clk);
        resetn = 1'b1;

        // name aok dok rdata allow br tgt | req addr valid ready chkbus bus
        addVec("fetch0",     1,0,0,      1,0,0,             1,RST_PC,       0,0,1,64'd0);
        addVec("wait0",      0,1,i0,     1,0,0,             0,0,            0,0,1,64'd0);
        addVec("hold0",      0,0,0,      1,0,0,             0,0,            1,1,1,{i0,RST_PC});
        addVec("fetch1",     1,0,0,      1,0,0,             1,RST_PC+4,     0,0,1,{i0,RST_PC});
        addVec("wait1",      0,1,i1,     1,0,0,             0,0,            0,0,0,64'd0);
        for (int k = 0; k < 5; k++)
            addVec("stall",  0,0,0,      0,0,0,             0,0,            1,1,1,{i1,RST_PC+32'd4});
        addVec("release",    0,0,0,      1,0,0,             0,0,            1,1,1,{i1,RST_PC+32'd4});
        addVec("fetch2",     1,0,0,      1,0,0,             1,RST_PC+8,     0,0,0,64'd0);
        addVec("wait_redir", 0,0,0,      1,1,32'h1c000100,  0,0,            0,0,0,64'd0);
        addVec("wait_canc1", 0,0,0,      1,0,0,             0,0,            0,0,1,{i1,RST_PC+32'd4});
        addVec("wait_canc2", 0,0,0,      1,0,0,             0,0,            0,0,1,{i1,RST_PC+32'd4});
        addVec("drop",       0,1,32'hdeadbeef,1,0,0,        0,0,            0,0,0,64'd0);
        addVec("req_redir",  0,0,0,      1,1,32'h1c000200,  1,32'h1c000100, 0,0,1,{i1,RST_PC+32'd4});
        addVec("req_target", 1,0,0,      1,0,0,             1,32'h1c000200, 0,0,0,64'd0);
        addVec("wait2",      0,1,i2,     1,0,0,             0,0,            0,0,0,64'd0);
        addVec("hold_redir", 0,0,0,      1,1,32'h1c000300,  0,0,            0,1,1,{i2,32'h1c000200});
        addVec("br_stall0",  1,0,0,      0,1,32'h1c000500,  1,32'h1c000300, 0,0,0,64'd0);
        addVec("br_stall1",  0,1,i3,     0,1,32'h1c000500,  0,0,            0,0,0,64'd0);
        addVec("br_stall2",  0,0,0,      0,1,32'h1c000500,  0,0,            1,1,1,{i3,32'h1c000300});
        addVec("br_taken",   0,0,0,      1,1,32'h1c000400,  0,0,            0,1,1,{i3,32'h1c000300});
        addVec("req_after",  0,0,0,      1,0,0,             1,32'h1c000400, 0,0,1,{i3,32'h1c000300});

        foreach (vecs[k])
            applyStimulus(vecs[k]);

        // Async reset while a fetch is outstanding.
        @(negedge clk);
        idleInputs();
        inst_sram_addr_ok = 1'b1;
        #1;
        checkOutput("rst_seq.req", 64'(inst_sram_req), 64'd1);
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("rst_seq.wait_req", 64'(inst_sram_req), 64'd0);
        resetn = 1'b0;
        #1;
        checkOutput("rst_seq.req_low", 64'(inst_sram_req), 64'd0);
        checkOutput("rst_seq.bus", IFreg_bus, 64'd0);
        checkOutput("rst_seq.valid", 64'(IFreg_valid), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checkOutput("rst_seq.refetch_req", 64'(inst_sram_req), 64'd1);
        checkOutput("rst_seq.refetch_addr", 64'(inst_sram_addr), 64'(RST_PC));

        // Clean restart for the randomized run.
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        pending = 1'b0; pend_addr = '0; pend_wait = 0; deliveries = 0;
        exp_pc = RST_PC; prev_stall = 1'b0; prev_bus = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            data_ok = pending && (pend_wait == 0);
            addr_ok = 1'($urandom_range(0, 1));
            allow   = ($urandom_range(0, 9) < 7);
            br      = ($urandom_range(0, 9) == 0);
            tgt     = {16'h1c00, 14'($urandom), 2'b00};
            inst_sram_data_ok = data_ok;
            inst_sram_rdata   = data_ok ? memWord(pend_addr) : $urandom;
            inst_sram_addr_ok = addr_ok;
            ID_allow_in       = allow;
            BR_BUS            = {tgt, br};
            #1;
            redirect = br & allow;

            if (inst_sram_req)
                checkOutput("rnd.req_while_busy", 64'(pending), 64'd0);
            checkOutput("rnd.valid_on_redirect", 64'(IFreg_valid & redirect), 64'd0);
            if (IFreg_valid) begin
                checkOutput("rnd.pc", 64'(IFreg_bus[31:0]), 64'(exp_pc));
                checkOutput("rnd.inst", 64'(IFreg_bus[63:32]), 64'(memWord(exp_pc)));
            end
            if (prev_stall) begin
                checkOutput("rnd.stall_bus", IFreg_bus, prev_bus);
                checkOutput("rnd.stall_ready", 64'(IF_ready_go), 64'd1);
            end

            if (IFreg_valid && allow) begin
                exp_pc = IFreg_bus[31:0] + 32'd4;
                deliveries++;
            end
            if (redirect)
                exp_pc = tgt;

            if (data_ok)
                pending = 1'b0;
            else if (pending)
                pend_wait--;
            if (inst_sram_req && addr_ok) begin
                pending   = 1'b1;
                pend_addr = inst_sram_addr;
                pend_wait = $urandom_range(0, 3);
            end

            prev_stall = IFreg_valid && !allow && !redirect;
            prev_bus   = IFreg_bus;
        end
        checkOutput("rnd.progress", 64'(deliveries >= 50), 64'd1);

        @(negedge clk);
        idleInputs();
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
